// File: rtl/pp_fsm_array.sv
// NCH independent copies of the SA/SB/SC/SD x/y Moore controller with per-channel enable and
// HOLD-cycle dwell in SD. Define PP_FSM_CNT_EN to build the per-channel SD->SA return counters.
module pp_fsm_array #(
   parameter int unsigned NCH  = 4,
   parameter int unsigned HOLD = 1,
   parameter int unsigned CW   = 8
) (
   input  logic                Clk,
   input  logic                Rst,
   input  logic [NCH-1:0]      en,
   input  logic [NCH-1:0]      x,
   input  logic [NCH-1:0]      y,
   input  logic                cnt_clr,
   output logic [NCH-1:0]      q,
   output logic [2*NCH-1:0]    state,
   output logic [NCH*CW-1:0]   cnt
);

   localparam int unsigned DW = $clog2(HOLD + 1);
   localparam logic [DW-1:0] DLAST = DW'(HOLD - 1);

   typedef enum logic [1:0] {
      SA = 2'd0,
      SB = 2'd1,
      SC = 2'd2,
      SD = 2'd3
   } st_t;

   function automatic logic out_of(input st_t s);
      return (s == SA) || (s == SD);
   endfunction

`ifndef PP_FSM_CNT_EN
   logic unused_cnt_clr;
   assign unused_cnt_clr = cnt_clr;
`endif

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      st_t           st;
      logic [DW-1:0] dwell;
      logic          q_r;
      logic          leave_sd;

      // Last dwell cycle of SD on an enabled edge: the SD->SA return.
      assign leave_sd = en[i] && (st == SD) && (dwell == DLAST);

      always_ff @(posedge Clk) begin
         if (Rst) begin
            st    <= SA;
            q_r   <= 1'b1;
            dwell <= '0;
         end else if (en[i]) begin
            q_r <= out_of(st);
            case (st)
               SA: st <= (x[i] | y[i]) ? SB : SC;
               SB: if (y[i]) st <= SC;
               SC: begin
                  if (!y[i]) begin
                     st    <= SD;
                     dwell <= '0;
                  end else if (x[i]) begin
                     st <= SA;
                  end
               end
               SD: begin
                  if (dwell == DLAST) begin
                     st    <= SA;
                     dwell <= '0;
                  end else begin
                     dwell <= dwell + 1'b1;
                  end
               end
               default: begin
                  st  <= SA;
                  q_r <= 1'b1;
               end
            endcase
         end
      end

      assign state[2*i +: 2] = st;
      assign q[i]            = q_r;

`ifdef PP_FSM_CNT_EN
      logic [CW-1:0] c;

      // Clear beats a coincident increment; counter saturates at all ones.
      always_ff @(posedge Clk) begin
         if (Rst || cnt_clr) begin
            c <= '0;
         end else if (leave_sd && (c != '1)) begin
            c <= c + 1'b1;
         end
      end

      assign cnt[CW*i +: CW] = c;
`else
      logic unused_leave_sd;
      assign unused_leave_sd = leave_sd;
      assign cnt[CW*i +: CW] = '0;
`endif
   end

endmodule

// File: tb/tb_pp_fsm_array.sv
// Directed bench for pp_fsm_array: a 4-channel HOLD=3 CW=2 instance and a 1-channel HOLD=1
// instance. Counter expectations follow whether PP_FSM_CNT_EN is defined.
module tb_pp_fsm_array;

`ifdef PP_FSM_CNT_EN
   localparam bit CntOn = 1'b1;
`else
   localparam bit CntOn = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       cnt_clr;
   logic [3:0] en, x, y, q;
   logic [7:0] state, cnt;
   logic       en1, x1, y1, q1;
   logic [1:0] state1;
   logic [7:0] cnt1;

   int tests = 0;
   int failed = 0;

   always #5 clk = ~clk;

   pp_fsm_array #(.NCH(4), .HOLD(3), .CW(2)) dut (
      .Clk(clk), .Rst(rst), .en(en), .x(x), .y(y), .cnt_clr(cnt_clr),
      .q(q), .state(state), .cnt(cnt)
   );

   pp_fsm_array #(.NCH(1), .HOLD(1), .CW(8)) dut1 (
      .Clk(clk), .Rst(rst), .en(en1), .x(x1), .y(y1), .cnt_clr(cnt_clr),
      .q(q1), .state(state1), .cnt(cnt1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full loop on channels 0 and 2 starting from SB, ending back in SB.
   task automatic run_loop(input logic clr_on_exit, input bit dwell_chk);
      x = 4'h0; y = 4'hF; step();
      if (dwell_chk) check("loop_sc", state, 8'h22);
      x = 4'h0; y = 4'h0; step();
      if (dwell_chk) begin
         check("loop_sd_enter", state, 8'h33);
         check("loop_q_sc", q, 4'hA);
      end
      step();
      if (dwell_chk) begin
         check("dwell_2", state, 8'h33);
         check("dwell_q2", q, 4'hF);
      end
      step();
      if (dwell_chk) begin
         check("dwell_3", state, 8'h33);
         check("dwell_q3", q, 4'hF);
      end
      cnt_clr = clr_on_exit; step(); cnt_clr = 1'b0;
      if (dwell_chk) begin
         check("dwell_exit", state, 8'h00);
         check("dwell_exit_q", q, 4'hF);
      end
      x = 4'hF; y = 4'h0; step();
      check("loop_sb", state, 8'h11);
   endtask

   logic [7:0] exp_cnt [6] = '{8'h11, 8'h22, 8'h33, 8'h33, 8'h00, 8'h11};

   initial begin
      rst = 1'b1; cnt_clr = 1'b0;
      en = 4'b1010; x = 4'b0110; y = 4'b0011;
      en1 = 1'b1; x1 = 1'b1; y1 = 1'b0;
      step(); step();
      check("rst_state", state, 8'h00);
      check("rst_q", q, 4'hF);
      check("rst_cnt", cnt, 8'h00);
      check("rst_state1", state1, 2'd0);
      check("rst_q1", q1, 1'b1);
      rst = 1'b0;

      // Single-channel walk, with an enable-low edge parked in SD.
      en = 4'h0; x1 = 1'b0; y1 = 1'b0;
      step();
      check("walk1_state", state1, 2'd2);
      check("walk1_q", q1, 1'b1);
      step();
      check("walk2_state", state1, 2'd3);
      check("walk2_q", q1, 1'b0);
      en1 = 1'b0; step();
      check("gate_state1", state1, 2'd3);
      check("gate_q1", q1, 1'b0);
      en1 = 1'b1; step();
      check("walk3_state", state1, 2'd0);
      check("walk3_q", q1, 1'b1);
      check("walk3_cnt", cnt1, CntOn ? 8'd1 : 8'd0);
      step();
      check("walk4_state", state1, 2'd2);
      check("walk4_q", q1, 1'b1);
      en1 = 1'b0;
      check("held_state", state, 8'h00);

      // Enable gating and channel independence.
      en = 4'b0101; x = 4'hF; y = 4'h0; step();
      check("gate_state", state, 8'h11);
      check("gate_q", q, 4'hF);

      for (int i = 0; i < 6; i++) begin
         run_loop(i == 4, i == 0);
         check($sformatf("loop%0d_cnt", i), cnt, CntOn ? exp_cnt[i] : 8'h00);
      end

      // Clear applies even with every channel disabled.
      en = 4'h0; cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
      check("clr_no_en", cnt, 8'h00);
      en = 4'b0101;
      run_loop(1'b0, 1'b0);
      check("pre_rst_cnt", cnt, CntOn ? 8'h11 : 8'h00);

      // Reset on the second SD edge aborts the dwell.
      x = 4'h0; y = 4'hF; step();
      x = 4'h0; y = 4'h0; step();
      check("pre_rst_sd", state, 8'h33);
      rst = 1'b1; step(); rst = 1'b0;
      check("mid_rst_state", state, 8'h00);
      check("mid_rst_q", q, 4'hF);
      check("mid_rst_cnt", cnt, 8'h00);
      x = 4'hF; y = 4'h0; step();
      check("re_sb", state, 8'h11);
      run_loop(1'b0, 1'b1);
      check("re_cnt", cnt, CntOn ? 8'h11 : 8'h00);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
